// File: rtl/muldiv_pkg.sv
// Shared constants for the multi-cycle multiply/divide sequencer and the ALU it borrows.
package muldiv_pkg;

    localparam int ITERS = 32;

    localparam logic [3:0] ALU_OP_ADD = 4'b0010;
    localparam logic [3:0] ALU_OP_SUB = 4'b0110;

    // op[1] = divide, op[0] = signed
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ABS_A  = 3'd1,
        ST_ABS_B  = 3'd2,
        ST_ITER   = 3'd3,
        ST_FIX_LO = 3'd4,
        ST_FIX_HI = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

endpackage

// File: rtl/muldiv_seq.sv
// MULT/MULTU/DIV/DIVU sequencer driving the shared ALU over 36 busy cycles.
// Divide support is compiled in only when MULDIV_DIV_EN is defined.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output logic [3:0]       alu_opselect,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_c_out,
    input  logic             alu_zero,
    output logic [2:0]       dbg_state
);
    import muldiv_pkg::*;

    localparam int CNT_W = $clog2(ITERS);

    // Handshake: start is taken only in IDLE or DONE; busy covers every cycle from
    // the accepting edge up to DONE; done is a single-cycle pulse and hi/lo/div_by_zero
    // hold their value until the next accepted start.

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic               lo_zero_q, lo_zero_d;
    logic               dbz_q, dbz_d;
`ifdef MULDIV_DIV_EN
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   hi_sh;
    logic               shift_out;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
`ifdef MULDIV_DIV_EN
                    state_d = ST_ABS_A;
`else
                    state_d = op[1] ? ST_DONE : ST_ABS_A;
`endif
                end
            end
            ST_ABS_A:  state_d = ST_ABS_B;
            ST_ABS_B:  state_d = ST_ITER;
            ST_ITER:   state_d = (cnt_q == CNT_W'(ITERS - 1)) ? ST_FIX_LO : ST_ITER;
            ST_FIX_LO: state_d = ST_FIX_HI;
            ST_FIX_HI: state_d = ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
    end

`ifdef MULDIV_DIV_EN
    assign hi_sh     = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    assign shift_out = hi_q[WIDTH-1];
`endif

    // ALU drive is purely a function of state; idle states request ADD(0, 0).
    always_comb begin
        alu_opselect = ALU_OP_ADD;
        alu_x        = '0;
        alu_y        = '0;
        busy         = 1'b0;
        done         = 1'b0;
        dbg_state    = state_q;
        case (state_q)
            ST_ABS_A: begin
                busy = 1'b1; alu_opselect = ALU_OP_SUB; alu_y = lo_q;
            end
            ST_ABS_B: begin
                busy = 1'b1; alu_opselect = ALU_OP_SUB; alu_y = b_q;
            end
            ST_ITER: begin
                busy = 1'b1; alu_x = hi_q; alu_y = b_q;
`ifdef MULDIV_DIV_EN
                if (is_div_q) begin
                    alu_opselect = ALU_OP_SUB; alu_x = hi_sh;
                end
`endif
            end
            ST_FIX_LO: begin
                busy = 1'b1; alu_opselect = ALU_OP_SUB; alu_y = lo_q;
            end
            ST_FIX_HI: begin
                busy = 1'b1; alu_x = ~hi_q; alu_y = {{(WIDTH-1){1'b0}}, lo_zero_q};
`ifdef MULDIV_DIV_EN
                if (is_div_q) begin
                    alu_opselect = ALU_OP_SUB; alu_x = '0; alu_y = hi_q;
                end
`endif
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            lo_zero_q <= 1'b0;
            dbz_q     <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_q  <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            lo_zero_q <= lo_zero_d;
            dbz_q     <= dbz_d;
`ifdef MULDIV_DIV_EN
            is_div_q  <= is_div_d;
`endif
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        lo_zero_d = lo_zero_q;
        dbz_d     = dbz_q;
`ifdef MULDIV_DIV_EN
        is_div_d  = is_div_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = rs;
                    b_d     = rt;
                    neg_a_d = op[0] & rs[WIDTH-1];
                    neg_b_d = op[0] & rt[WIDTH-1];
                    dbz_d   = 1'b0;
`ifdef MULDIV_DIV_EN
                    is_div_d = op[1];
`else
                    if (op[1]) lo_d = '0;
`endif
                end
            end
            ST_ABS_A: if (neg_a_q) lo_d = alu_res;
            ST_ABS_B: if (neg_b_q) b_d = alu_res;
            ST_ITER: begin
                cnt_d = cnt_q + 1'b1;
`ifdef MULDIV_DIV_EN
                if (is_div_q) begin
                    // Restoring step: a set shifted-out bit means the partial remainder exceeds B.
                    if (shift_out || alu_c_out) begin
                        hi_d = alu_res;
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = hi_sh;
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end else
`endif
                if (lo_q[0]) {hi_d, lo_d} = {alu_c_out, alu_res, lo_q[WIDTH-1:1]};
                else         {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
            end
            ST_FIX_LO: begin
                lo_zero_d = alu_zero;
                if (neg_a_q ^ neg_b_q) lo_d = alu_res;
            end
            ST_FIX_HI: begin
`ifdef MULDIV_DIV_EN
                if (is_div_q) begin
                    if (neg_a_q) hi_d = alu_res;
                    dbz_d = (b_q == '0);
                end else
`endif
                if (neg_a_q ^ neg_b_q) hi_d = alu_res;
            end
            default: ;
        endcase
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq with a behavioural model of the shared ALU.
// Divide vectors are selected by MULDIV_DIV_EN to match the build.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int W = 65;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic        busy, done, dbz;
    logic [31:0] hi, lo;
    logic [3:0]  alu_opselect;
    logic [31:0] alu_x, alu_y, alu_res;
    logic        alu_c_out, alu_zero;
    logic [2:0]  dbg_state;
    logic [32:0] alu_sum;

    logic [W-1:0] exp_q[$];
    int           lat_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;

    muldiv_seq #(.WIDTH(32), .ITERS(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs(rs), .rt(rt),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(dbz),
        .alu_opselect(alu_opselect), .alu_x(alu_x), .alu_y(alu_y),
        .alu_res(alu_res), .alu_c_out(alu_c_out), .alu_zero(alu_zero),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // shared ALU model: SUB carry-out means x >= y unsigned
    always_comb begin
        if (alu_opselect == ALU_OP_SUB) alu_sum = {1'b0, alu_x} + {1'b0, ~alu_y} + 33'd1;
        else                            alu_sum = {1'b0, alu_x} + {1'b0, alu_y};
    end
    assign alu_res   = alu_sum[31:0];
    assign alu_c_out = alu_sum[32];
    assign alu_zero  = (alu_sum[31:0] == 32'd0);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // driver: call just after a negedge; the following posedge accepts
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [W-1:0] e, input int lat, input bit push);
        op = o; rs = a; rt = b; start = 1'b1;
        if (push) begin
            exp_q.push_back(e);
            lat_q.push_back(cyc + lat);
        end
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom_range(0, 3));
        rs = $urandom;
        rt = $urandom;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d pending, expected 0", exp_q.size());
            exp_q.delete(); lat_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: done=%0b expected 1", done);
        end
    endtask

    // monitor / scoreboard
    initial begin
        logic [W-1:0] e;
        int           l;
        forever begin
            @(negedge clk);
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    l = lat_q.pop_front();
                    check("hi", 64'(hi), 64'(e[63:32]));
                    check("lo", 64'(lo), 64'(e[31:0]));
                    check("div_by_zero", 64'(dbz), 64'(e[64]));
                    check("latency", 64'(cyc), 64'(l));
                    check("busy_with_done", 64'(busy), 64'd0);
                end
            end
        end
    end

    initial begin
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_dbz", 64'(dbz), 64'd0);
        check("rst_alu_op", 64'(alu_opselect), 64'(ALU_OP_ADD));
        check("rst_alu_x", 64'(alu_x), 64'd0);
        check("rst_alu_y", 64'(alu_y), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, {1'b0, 32'hFFFFFFFE, 32'h00000001}, 37, 1'b1);
        wait_drain(60);
        issue(OP_MULT, 32'hFFFFFFFD, 32'd7, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB}, 37, 1'b1);
        wait_drain(60);
        issue(OP_MULT, 32'h80000000, 32'h80000000, {1'b0, 32'h40000000, 32'h00000000}, 37, 1'b1);
        wait_drain(60);
        issue(OP_MULT, 32'd5, 32'hFFFFFFFF, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFB}, 37, 1'b1);
        wait_drain(60);
        issue(OP_MULT, 32'hFFFFFFFF, 32'd0, {1'b0, 32'h00000000, 32'h00000000}, 37, 1'b1);
        wait_drain(60);
        issue(OP_MULTU, 32'h12345678, 32'h10, {1'b0, 32'h00000001, 32'h23456780}, 37, 1'b1);
        wait_drain(60);

`ifdef MULDIV_DIV_EN
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD}, 37, 1'b1);
        wait_drain(60);
        issue(OP_DIV, 32'd7, 32'hFFFFFFFE, {1'b0, 32'h00000001, 32'hFFFFFFFD}, 37, 1'b1);
        wait_drain(60);
        issue(OP_DIVU, 32'd100, 32'd7, {1'b0, 32'd2, 32'd14}, 37, 1'b1);
        wait_drain(60);
        issue(OP_DIVU, 32'h1234, 32'd0, {1'b1, 32'h00001234, 32'hFFFFFFFF}, 37, 1'b1);
        wait_drain(60);
        issue(OP_MULTU, 32'd2, 32'd3, {1'b0, 32'd0, 32'd6}, 37, 1'b1);
        wait_drain(60);
`else
        issue(OP_DIVU, 32'd100, 32'd7, {1'b0, 32'd0, 32'd0}, 1, 1'b1);
        wait_drain(10);
`endif

        // start while busy is dropped
        issue(OP_MULTU, 32'h10, 32'h20, {1'b0, 32'd0, 32'h200}, 37, 1'b1);
        repeat (8) @(negedge clk);
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, '0, 37, 1'b0);
        wait_drain(60);

        // reset mid-operation aborts with no done
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, '0, 37, 1'b0);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // back-to-back: second start lands in the DONE cycle
        issue(OP_MULTU, 32'd7, 32'd6, {1'b0, 32'd0, 32'd42}, 37, 1'b1);
        wait_done(60);
        issue(OP_MULT, 32'hFFFFFFFD, 32'd7, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB}, 37, 1'b1);
        wait_drain(60);
`ifndef MULDIV_DIV_EN
        issue(OP_MULTU, 32'd9, 32'd9, {1'b0, 32'd0, 32'd81}, 37, 1'b1);
        wait_done(60);
        issue(OP_DIVU, 32'd100, 32'd7, {1'b0, 32'd0, 32'd0}, 1, 1'b1);
        wait_drain(10);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the MIPS core. It owns no adder of its own: it drives the shared 32-bit `alu` through its opselect/x/y inputs and sequences it over 37 cycles to produce a 64-bit HI/LO result. It sits beside the execute stage, which starts it with a one-cycle pulse and stalls on `busy` until `done`.

## Interface
- `WIDTH`, 32, operand/ALU width; only 32 is supported.
- `ITERS`, 32, shift/add or shift/subtract iterations; must equal `WIDTH`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request pulse, sampled in IDLE or DONE only.
- `op` in 2: bit1 = divide, bit0 = signed.
  - 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `rs` in 32: multiplicand or dividend.
- `rt` in 32: multiplier or divisor.
- `busy` out 1: high from the accepting edge through FIX_HI.
- `done` out 1: one-cycle pulse in DONE.
- `hi` out 32, `lo` out 32: result, valid from `done` until the next accepted start.
  - Multiply: product {hi,lo}.
  - Divide: lo = quotient, hi = remainder.
- `div_by_zero` out 1: set with `done` when a divide had `rt == 0`; cleared on the next accepted start.
- `alu_opselect` out 4, `alu_x` out 32, `alu_y` out 32: drive the shared ALU.
- `alu_res` in 32, `alu_c_out` in 1, `alu_zero` in 1: ALU outputs, sampled in the same cycle.

## Operation
- FSM states: IDLE → ABS_A → ABS_B → ITER (32 cycles, 5-bit counter) → FIX_LO → FIX_HI → DONE → IDLE.
  - `start` in DONE goes directly to ABS_A.
- On accept: latch `op`, `rs` into A, `rt` into B. Record `neg_a = op[0] & rs[31]` and `neg_b = op[0] & rt[31]`.
- ABS_A / ABS_B: drive ALU SUB(0, A) or SUB(0, B). Load `alu_res` into the register only if neg_a / neg_b is set.
  - 0x80000000 maps to the unsigned magnitude 2^31.
- ITER, multiply (shift-add):
  - Drive ADD(hi, B).
  - If lo[0] = 1: {hi,lo} ← {alu_c_out, alu_res, lo} >> 1.
  - Otherwise: {hi,lo} ← {0, hi, lo} >> 1.
  - hi starts at 0 and lo starts at |A|.
- ITER, divide (restoring):
  - Shift {hi,lo} left by 1 and keep the shifted-out bit s.
  - Drive SUB(hi_shifted, B).
  - If s = 1 or alu_c_out = 1 (no borrow): hi ← alu_res and lo[0] ← 1.
  - Otherwise: hi ← hi_shifted and lo[0] ← 0.
- FIX_LO:
  - Multiply: negate when neg_a ^ neg_b. Drive SUB(0, lo) and latch `lo_zero = alu_zero`.
  - Divide: negate the quotient when neg_a ^ neg_b, via SUB(0, lo).
- FIX_HI:
  - Multiply: when negating, drive ADD(~hi, {31'b0, lo_zero}).
  - Divide: negate the remainder when neg_a, via SUB(0, hi).
- In every non-fix state where no write is needed, the ALU is still driven but the result is discarded.
- Divide by zero: run the full sequence with no special casing.
  - DIVU gives lo = 0xFFFFFFFF, hi = rs.
  - `div_by_zero` = 1.
- ALU codes are ALU_OP_ADD = 4'b0010 and ALU_OP_SUB = 4'b0110. SUB's `c_out` = 1 means x ≥ y unsigned.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `busy` 0, `done` 0, `hi` 0, `lo` 0, `div_by_zero` 0, counter 0, `alu_opselect` ALU_OP_ADD, `alu_x` 0, `alu_y` 0.
- The ALU outputs are combinational from state. In IDLE/DONE they are ADD(0, 0).
- Latency: `done` is high in the cycle that starts 37 edges after the accepting edge (ABS 2 + ITER 32 + FIX 2, then DONE).
- `busy` rises on the accepting edge and falls on entry to DONE. `busy` and `done` are never high together.
- `start` while busy is ignored, with no queuing.
- `rst_n` low mid-operation aborts immediately. Partial hi/lo are cleared, and no `done` is produced.
- Changing `rs`, `rt` or `op` after the accepting edge has no effect.

## Configuration
- `MULDIV_DIV_EN` defined: all four ops are supported as above.
- `MULDIV_DIV_EN` undefined:
  - Divide hardware (restoring step, s tracking, remainder fixup, `div_by_zero` logic) is compiled out.
  - `op[1] = 1` requests are accepted but go IDLE → DONE in one cycle, with `hi` = `lo` = 0 and `div_by_zero` = 0.
  - Multiply behaviour and latency are unchanged.

## Structure
- Shared package `muldiv_pkg` holds:
  - ALU_OP_ADD and ALU_OP_SUB constants (shared with `alu`).
  - The `op` encoding constants.
  - The FSM state enum.
  - ITERS = 32.
- No sub-module. The FSM and datapath form one module; the ALU is external and shared, and the execute stage muxes its inputs while `busy`.

## Test plan
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF → done at +37, hi=0xFFFFFFFE, lo=0x00000001.
- MULT rs=-3 (0xFFFFFFFD), rt=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT rs=0x80000000, rt=0x80000000 → hi=0x40000000, lo=0.
- DIV rs=-7, rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=100, rt=7 → lo=14, hi=2.
- DIVU rs=0x1234, rt=0 → lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1 with done.
- Start MULTU, pulse start again at +10 with different operands → ignored, first result returned at +37. Assert rst_n=0 at +20 → busy=0, hi=lo=0 immediately, no done.
- Back-to-back: start asserted in the DONE cycle → second op accepted, its done 37 cycles later; without MULDIV_DIV_EN, DIVU → done next cycle, hi=lo=0.
